// File: rtl/free_list_mw.sv
// Circular free list of physical register tags for rename: multi-lane allocate and release,
// with head-pointer checkpoints so a mispredict reclaims wrong-path allocations in one cycle.
module free_list_mw #(
    parameter int NUM_PREGS   = 128,
    parameter int NUM_ARCH    = 32,
    parameter int ALLOC_WIDTH = 2,
    parameter int FREE_WIDTH  = 2,
    parameter int NUM_CKPT    = 4,
    localparam int PW    = $clog2(NUM_PREGS),
    localparam int CW    = $clog2(NUM_CKPT),
    localparam int NFREE = NUM_PREGS - NUM_ARCH,
    localparam int DEPTH = 2 ** $clog2(NFREE),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ALLOC_WIDTH-1:0]    alloc_req_i,
    output logic                      alloc_gnt_o,
    output logic [ALLOC_WIDTH*PW-1:0] alloc_preg_o,
    input  logic [FREE_WIDTH-1:0]     free_valid_i,
    input  logic [FREE_WIDTH*PW-1:0]  free_preg_i,
    input  logic                      ckpt_save_i,
    input  logic [CW-1:0]             ckpt_id_i,
    input  logic                      restore_i,
    input  logic [CW-1:0]             restore_id_i,
    output logic [AW:0]               free_count_o,
    output logic                      empty_o
);

    logic [PW-1:0] queue_q [DEPTH];
    logic [AW:0]   head_q, head_d;
    logic [AW:0]   tail_q, tail_d;
    logic [AW:0]   ckpt_q [NUM_CKPT];

    logic [AW:0]   n_alloc, n_rel, a_off, f_off;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx [FREE_WIDTH];

    assign free_count_o = tail_q - head_q;
    assign empty_o      = (free_count_o == '0);

    // Requested lanes take consecutive head entries in ascending lane order.
    always_comb begin
        n_alloc      = '0;
        a_off        = '0;
        rd_idx       = '0;
        alloc_preg_o = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            n_alloc = n_alloc + {{AW{1'b0}}, alloc_req_i[i]};
        end
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (alloc_req_i[i]) begin
                rd_idx = head_q[AW-1:0] + a_off[AW-1:0];
                alloc_preg_o[i*PW +: PW] = queue_q[rd_idx];
                a_off = a_off + 1'b1;
            end
        end
        alloc_gnt_o = !restore_i && (n_alloc != '0) && (free_count_o >= n_alloc);
    end

    // Valid release lanes are compacted onto consecutive tail entries.
    always_comb begin
        n_rel = '0;
        f_off = '0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            wr_idx[i] = tail_q[AW-1:0] + f_off[AW-1:0];
            if (free_valid_i[i]) f_off = f_off + 1'b1;
        end
        n_rel  = f_off;
        tail_d = tail_q + n_rel;
        if (restore_i)        head_d = ckpt_q[restore_id_i];
        else if (alloc_gnt_o) head_d = head_q + n_alloc;
        else                  head_d = head_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                queue_q[k] <= (k < NFREE) ? PW'(NUM_ARCH + k) : '0;
            end
            for (int c = 0; c < NUM_CKPT; c++) begin
                ckpt_q[c] <= '0;
            end
            head_q <= '0;
            tail_q <= (AW+1)'(NFREE);
        end else begin
            for (int i = 0; i < FREE_WIDTH; i++) begin
                if (free_valid_i[i]) queue_q[wr_idx[i]] <= free_preg_i[i*PW +: PW];
            end
            // Checkpoint captures the post-grant (or restored) head of this cycle.
            if (ckpt_save_i) ckpt_q[ckpt_id_i] <= head_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !restore_i) begin
            assert (int'(free_count_o) - (alloc_gnt_o ? int'(n_alloc) : 0) + int'(n_rel) <= NFREE);
        end
    end

endmodule

// File: tb/tb_free_list_mw.sv
// Directed bench for free_list_mw: reset, lane compaction, drain/empty, checkpoint restore,
// pointer wrap and mid-stream reset.
module tb_free_list_mw;

    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    alloc_req;
    logic          alloc_gnt;
    logic [13:0]   alloc_preg;
    logic [1:0]    free_valid;
    logic [13:0]   free_preg;
    logic          ckpt_save;
    logic [1:0]    ckpt_id;
    logic          restore;
    logic [1:0]    restore_id;
    logic [7:0]    free_count;
    logic          empty;

    int n_asrt = 0;
    int n_fail = 0;

    free_list_mw dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .alloc_req_i  (alloc_req),
        .alloc_gnt_o  (alloc_gnt),
        .alloc_preg_o (alloc_preg),
        .free_valid_i (free_valid),
        .free_preg_i  (free_preg),
        .ckpt_save_i  (ckpt_save),
        .ckpt_id_i    (ckpt_id),
        .restore_i    (restore),
        .restore_id_i (restore_id),
        .free_count_o (free_count),
        .empty_o      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req  = '0;
        free_valid = '0;
        free_preg  = '0;
        ckpt_save  = 1'b0;
        ckpt_id    = '0;
        restore    = 1'b0;
        restore_id = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int lane(input int i);
        logic [13:0] v;
        v = alloc_preg;
        return int'(v[i*PW +: PW]);
    endfunction

    initial begin
        int e0, e1;
        rst = 1'b0;
        idle();

        // 1: reset state and first dual allocation
        do_reset();
        #1;
        chk("rst_count", free_count, 96);
        chk("rst_empty", empty, 0);
        alloc_req = 2'b11;
        #1;
        chk("t1_gnt", alloc_gnt, 1);
        chk("t1_lane0", lane(0), 32);
        chk("t1_lane1", lane(1), 33);
        tick();
        alloc_req = 2'b00;
        #1;
        chk("t1_count", free_count, 94);
        chk("t1_idle_gnt", alloc_gnt, 0);

        // 2: lane 1 only gets the head tag; lane 0 drives 0
        do_reset();
        alloc_req = 2'b10;
        #1;
        chk("t2_gnt", alloc_gnt, 1);
        chk("t2_lane0", lane(0), 0);
        chk("t2_lane1", lane(1), 32);
        tick();
        alloc_req = 2'b01;
        #1;
        chk("t2_count", free_count, 95);
        chk("t2_next_lane0", lane(0), 33);
        tick();

        // 3: drain, all-or-nothing, empty, no same-cycle bypass of a release
        do_reset();
        alloc_req = 2'b11;
        repeat (47) tick();
        alloc_req = 2'b01;
        #1;
        chk("t3_count2", free_count, 2);
        chk("t3_lane0_126", lane(0), 126);
        tick();
        alloc_req = 2'b11;
        #1;
        chk("t3_count1", free_count, 1);
        chk("t3_partial_gnt", alloc_gnt, 0);
        tick();
        alloc_req = 2'b01;
        #1;
        chk("t3_head_held", free_count, 1);
        chk("t3_single_gnt", alloc_gnt, 1);
        chk("t3_lane0_127", lane(0), 127);
        tick();
        free_valid = 2'b01;
        free_preg  = 14'd5;
        #1;
        chk("t3_empty", empty, 1);
        chk("t3_no_bypass", alloc_gnt, 0);
        tick();
        free_valid = 2'b00;
        free_preg  = '0;
        #1;
        chk("t3_freed_count", free_count, 1);
        chk("t3_freed_gnt", alloc_gnt, 1);
        chk("t3_freed_tag", lane(0), 5);
        tick();
        alloc_req = 2'b00;
        #1;
        chk("t3_empty_again", empty, 1);

        // 4: checkpoint with same-cycle allocation, then restore
        do_reset();
        alloc_req = 2'b11;
        ckpt_save = 1'b1;
        ckpt_id   = 2'd2;
        #1;
        chk("t4_lane0", lane(0), 32);
        chk("t4_lane1", lane(1), 33);
        tick();
        ckpt_save = 1'b0;
        tick();
        tick();
        restore    = 1'b1;
        restore_id = 2'd2;
        #1;
        chk("t4_pre_count", free_count, 90);
        chk("t4_restore_gnt", alloc_gnt, 0);
        tick();
        restore   = 1'b0;
        alloc_req = 2'b01;
        #1;
        chk("t4_post_count", free_count, 94);
        chk("t4_post_lane0", lane(0), 34);
        tick();

        // 5: steady alloc/free pairs wrap both pointers; tags recycle in release order
        do_reset();
        for (int c = 0; c < 200; c++) begin
            e0 = 32 + ((2 * c) % 96);
            e1 = 32 + ((2 * c + 1) % 96);
            alloc_req  = 2'b11;
            free_valid = 2'b11;
            free_preg  = {7'(e1), 7'(e0)};
            #1;
            chk("t5_count", free_count, 96);
            chk("t5_gnt", alloc_gnt, 1);
            chk("t5_lane0", lane(0), e0);
            chk("t5_lane1", lane(1), e1);
            tick();
        end
        idle();

        // 6: reset overrides restore/alloc/free/save in the same cycle
        do_reset();
        alloc_req = 2'b11;
        repeat (3) tick();
        rst        = 1'b1;
        restore    = 1'b1;
        restore_id = 2'd1;
        ckpt_save  = 1'b1;
        ckpt_id    = 2'd1;
        free_valid = 2'b11;
        free_preg  = {7'd2, 7'd1};
        tick();
        rst = 1'b0;
        idle();
        alloc_req = 2'b01;
        #1;
        chk("t6_count", free_count, 96);
        chk("t6_gnt", alloc_gnt, 1);
        chk("t6_lane0", lane(0), 32);
        tick();
        alloc_req  = 2'b00;
        restore    = 1'b1;
        restore_id = 2'd1;
        tick();
        restore = 1'b0;
        #1;
        chk("t6_ckpt_cleared", free_count, 96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
